// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg
// Shared definitions for the MIPS instruction-fetch stage:
//   - fetch_state_e : fetch FSM states (BOOT, FETCH, HOLD)
//   - JMP_*         : one-hot jump codes driven by the controller
//   - NOP           : instruction word substituted when a fetch times out
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    localparam logic [3:0] JMP_J    = 4'b0001;
    localparam logic [3:0] JMP_JAL  = 4'b0010;
    localparam logic [3:0] JMP_JR   = 4'b0100;
    localparam logic [3:0] JMP_JALR = 4'b1000;

    localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/next_pc_sel.sv
// next_pc_sel
// Purely combinational next-PC selection for the fetch stage.
// Ports:
//   pc_plus4    in  32  address of the sequentially next instruction
//   instr_index in  26  jump target field of the current instruction
//   jump        in  4   one-hot jump code (J, JAL, JR, JALR)
//   pcsrc       in  1   branch taken
//   imm         in  32  sign-extended branch word offset
//   jr_target   in  32  register value for JR/JALR
//   next_pc     out 32  selected next PC
module next_pc_sel
    import mips_fetch_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr_index,
    input  logic [3:0]  jump,
    input  logic        pcsrc,
    input  logic [31:0] imm,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc
);

    logic [31:0] jump_target;
    logic [31:0] reg_target;
    logic [31:0] branch_target;
    logic        is_direct_jump;
    logic        is_reg_jump;

    assign jump_target   = {pc_plus4[31:28], instr_index, 2'b00};
    assign reg_target    = jr_target & 32'hFFFF_FFFC;
    assign branch_target = pc_plus4 + (imm << 2);

    // If several jump bits are set the lowest one wins, so any J/JAL bit
    // beats any JR/JALR bit. Jumps of either kind override a taken branch.
    assign is_direct_jump = |(jump & (JMP_J | JMP_JAL));
    assign is_reg_jump    = |(jump & (JMP_JR | JMP_JALR));

    always_comb begin
        next_pc = pc_plus4;
        if (is_direct_jump) begin
            next_pc = jump_target;
        end else if (is_reg_jump) begin
            next_pc = reg_target;
        end else if (pcsrc) begin
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch stage feeding the MIPS controller/datapath. Holds the PC,
// fetches one word at a time over a req/ack handshake, presents it until the
// datapath retires it, then moves to the next PC chosen by the controller.
// A fetch that waits TIMEOUT cycles without ack is replaced by a NOP and
// flags fetch_err (sticky until reset).
// Ports:
//   clk, reset                      clock (rising edge), async active-low reset
//   imem_req/imem_addr              fetch request and address (= pc)
//   imem_ack/imem_rdata             memory response
//   instr/instr_valid               registered instruction awaiting retirement
//   pc/pc_plus4                     current instruction address and pc + 4
//   advance                         datapath retires the current instruction
//   pcsrc/jump/imm/jr_target        controller next-PC controls
//   fetch_err                       sticky fetch-timeout flag
module fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        advance,
    input  logic        pcsrc,
    input  logic [3:0]  jump,
    input  logic [31:0] imm,
    input  logic [31:0] jr_target,
    output logic        fetch_err
);

    // The counter holds the number of ack-less FETCH cycles already elapsed,
    // so expiry happens on the edge that ends the TIMEOUT-th such cycle.
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;
    logic         err_q, err_d;
    logic         req_q, req_d;
    logic [7:0]   wait_q, wait_d;
    logic [31:0]  next_pc;

    assign pc_plus4    = pc_q + 32'd4;
    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign imem_req    = req_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign fetch_err   = err_q;

    next_pc_sel u_next_pc_sel (
        .pc_plus4    (pc_plus4),
        .instr_index (instr_q[25:0]),
        .jump        (jump),
        .pcsrc       (pcsrc),
        .imm         (imm),
        .jr_target   (jr_target),
        .next_pc     (next_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        err_d   = err_q;
        wait_d  = wait_q;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
                wait_d  = 8'd0;
            end
            FETCH: begin
                // An ack arriving on the expiry cycle still delivers real data.
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else if (wait_q == WAIT_LIMIT) begin
                    instr_d = NOP;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = HOLD;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            HOLD: begin
                if (advance) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    wait_d  = 8'd0;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
        // Registered request follows the state being entered, so it rises on
        // the same edge that enters FETCH and falls on the edge that leaves it.
        req_d = (state_d == FETCH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            req_q   <= req_d;
            wait_q  <= wait_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed bench for fetch_unit (RESET_PC = 0, TIMEOUT = 15). Inputs change
// 1 ns after each rising edge and outputs are sampled at that same point.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        advance = 1'b0;
    logic        pcsrc = 1'b0;
    logic [3:0]  jump = 4'b0000;
    logic [31:0] imm = 32'h0;
    logic [31:0] jr_target = 32'h0;
    logic        fetch_err;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(15)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .advance     (advance),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .imm         (imm),
        .jr_target   (jr_target),
        .fetch_err   (fetch_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory answers the outstanding request for exactly one cycle.
    task automatic serve(input logic [31:0] data);
        imem_rdata = data;
        imem_ack   = 1'b1;
        tick();
        imem_ack   = 1'b0;
    endtask

    // Datapath retires the held instruction with the given controller outputs.
    task automatic retire(input logic p, input logic [3:0] j, input logic [31:0] im, input logic [31:0] jr);
        advance   = 1'b1;
        pcsrc     = p;
        jump      = j;
        imm       = im;
        jr_target = jr;
        tick();
        advance   = 1'b0;
        pcsrc     = 1'b0;
        jump      = 4'b0000;
        imm       = 32'h0;
        jr_target = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        n_checks++; if (imem_req !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_req: got %b expected 0", imem_req); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_valid: got %b expected 0", instr_valid); end
        n_checks++; if (instr !== 32'h0) begin n_fails++; $display("[TB] FAIL rst_instr: got %h expected 00000000", instr); end
        n_checks++; if (pc !== 32'h0) begin n_fails++; $display("[TB] FAIL rst_pc: got %h expected 00000000", pc); end
        n_checks++; if (fetch_err !== 1'b0) begin n_fails++; $display("[TB] FAIL rst_err: got %b expected 0", fetch_err); end
        n_checks++; if (pc_plus4 !== 32'h4) begin n_fails++; $display("[TB] FAIL rst_pc4: got %h expected 00000004", pc_plus4); end
    endtask

    task automatic test_boot();
        reset = 1'b1;
        n_checks++; if (imem_req !== 1'b0) begin n_fails++; $display("[TB] FAIL boot_req_early: got %b expected 0", imem_req); end
        tick();
        n_checks++; if (imem_req !== 1'b1) begin n_fails++; $display("[TB] FAIL boot_req: got %b expected 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fails++; $display("[TB] FAIL boot_addr: got %h expected 00000000", imem_addr); end
        serve(32'h2008_0005);
        n_checks++; if (instr !== 32'h2008_0005) begin n_fails++; $display("[TB] FAIL boot_instr: got %h expected 20080005", instr); end
        n_checks++; if (instr_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL boot_valid: got %b expected 1", instr_valid); end
        n_checks++; if (imem_req !== 1'b0) begin n_fails++; $display("[TB] FAIL boot_req_drop: got %b expected 0", imem_req); end
    endtask

    task automatic test_sequential();
        retire(1'b0, 4'b0000, 32'h0, 32'h0);
        n_checks++; if (imem_req !== 1'b1) begin n_fails++; $display("[TB] FAIL seq_req: got %b expected 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h4) begin n_fails++; $display("[TB] FAIL seq_addr: got %h expected 00000004", imem_addr); end
        n_checks++; if (pc_plus4 !== 32'h8) begin n_fails++; $display("[TB] FAIL seq_pc4: got %h expected 00000008", pc_plus4); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL seq_valid: got %b expected 0", instr_valid); end
        for (int i = 0; i < 3; i++) begin
            serve(32'h0000_0000);
            retire(1'b0, 4'b0000, 32'h0, 32'h0);
        end
        n_checks++; if (imem_addr !== 32'h10) begin n_fails++; $display("[TB] FAIL seq_walk_addr: got %h expected 00000010", imem_addr); end
    endtask

    task automatic test_branch();
        serve(32'h1111_1111);
        retire(1'b1, 4'b0000, 32'hFFFF_FFFE, 32'h0);
        n_checks++; if (imem_addr !== 32'h0C) begin n_fails++; $display("[TB] FAIL br_back_addr: got %h expected 0000000c", imem_addr); end
        serve(32'h0800_0100);
        retire(1'b1, 4'b0001, 32'hFFFF_FFFE, 32'h0);
        n_checks++; if (imem_addr !== 32'h400) begin n_fails++; $display("[TB] FAIL br_j_override: got %h expected 00000400", imem_addr); end
    endtask

    task automatic test_jumps();
        // J and JR both set: the J target must win over jr_target.
        serve(32'h0810_0004);
        retire(1'b0, 4'b0101, 32'h0, 32'h1234_5678);
        n_checks++; if (imem_addr !== 32'h0040_0010) begin n_fails++; $display("[TB] FAIL jmp_multi: got %h expected 00400010", imem_addr); end
        serve(32'h0000_0000);
        retire(1'b1, 4'b0100, 32'h5, 32'h0040_0023);
        n_checks++; if (imem_addr !== 32'h0040_0020) begin n_fails++; $display("[TB] FAIL jmp_jr: got %h expected 00400020", imem_addr); end
        serve(32'h0000_0000);
        retire(1'b0, 4'b1000, 32'h0, 32'h0000_0101);
        n_checks++; if (imem_addr !== 32'h100) begin n_fails++; $display("[TB] FAIL jmp_jalr: got %h expected 00000100", imem_addr); end
        n_checks++; if (pc_plus4 !== 32'h104) begin n_fails++; $display("[TB] FAIL jmp_jalr_pc4: got %h expected 00000104", pc_plus4); end
        serve(32'h0C00_0080);
        retire(1'b0, 4'b0010, 32'h0, 32'h0);
        n_checks++; if (imem_addr !== 32'h200) begin n_fails++; $display("[TB] FAIL jmp_jal: got %h expected 00000200", imem_addr); end
    endtask

    task automatic test_ignored_inputs();
        advance   = 1'b1;
        jump      = 4'b0100;
        jr_target = 32'h0000_ABC0;
        repeat (4) tick();
        advance   = 1'b0;
        jump      = 4'b0000;
        jr_target = 32'h0;
        n_checks++; if (pc !== 32'h200) begin n_fails++; $display("[TB] FAIL ign_adv_pc: got %h expected 00000200", pc); end
        n_checks++; if (imem_req !== 1'b1) begin n_fails++; $display("[TB] FAIL ign_adv_req: got %b expected 1", imem_req); end
        serve(32'hCAFE_0001);
        imem_ack   = 1'b1;
        imem_rdata = 32'h5555_5555;
        repeat (2) tick();
        imem_ack   = 1'b0;
        n_checks++; if (instr !== 32'hCAFE_0001) begin n_fails++; $display("[TB] FAIL ign_ack_instr: got %h expected cafe0001", instr); end
        n_checks++; if (imem_req !== 1'b0) begin n_fails++; $display("[TB] FAIL ign_ack_req: got %b expected 0", imem_req); end
    endtask

    task automatic test_wrap();
        retire(1'b0, 4'b0100, 32'h0, 32'hFFFF_FFFF);
        n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fails++; $display("[TB] FAIL wrap_top: got %h expected fffffffc", imem_addr); end
        n_checks++; if (pc_plus4 !== 32'h0) begin n_fails++; $display("[TB] FAIL wrap_pc4: got %h expected 00000000", pc_plus4); end
        serve(32'h7777_0000);
        retire(1'b0, 4'b0000, 32'h0, 32'h0);
        n_checks++; if (imem_addr !== 32'h0) begin n_fails++; $display("[TB] FAIL wrap_addr: got %h expected 00000000", imem_addr); end
    endtask

    task automatic test_timeout();
        // The previous fetch waited several cycles; the counter must restart.
        repeat (14) tick();
        n_checks++; if (instr_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL to_early_valid: got %b expected 0", instr_valid); end
        n_checks++; if (fetch_err !== 1'b0) begin n_fails++; $display("[TB] FAIL to_early_err: got %b expected 0", fetch_err); end
        tick();
        n_checks++; if (instr_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL to_valid: got %b expected 1", instr_valid); end
        n_checks++; if (instr !== 32'h0) begin n_fails++; $display("[TB] FAIL to_nop: got %h expected 00000000", instr); end
        n_checks++; if (fetch_err !== 1'b1) begin n_fails++; $display("[TB] FAIL to_err: got %b expected 1", fetch_err); end
        n_checks++; if (pc !== 32'h0) begin n_fails++; $display("[TB] FAIL to_pc: got %h expected 00000000", pc); end
        n_checks++; if (imem_req !== 1'b0) begin n_fails++; $display("[TB] FAIL to_req: got %b expected 0", imem_req); end
        retire(1'b0, 4'b0000, 32'h0, 32'h0);
        n_checks++; if (imem_addr !== 32'h4) begin n_fails++; $display("[TB] FAIL to_next_addr: got %h expected 00000004", imem_addr); end
        serve(32'h1234_0000);
        n_checks++; if (instr !== 32'h1234_0000) begin n_fails++; $display("[TB] FAIL to_after_instr: got %h expected 12340000", instr); end
        n_checks++; if (fetch_err !== 1'b1) begin n_fails++; $display("[TB] FAIL to_sticky: got %b expected 1", fetch_err); end
    endtask

    task automatic test_reset_mid();
        retire(1'b0, 4'b0000, 32'h0, 32'h0);
        n_checks++; if (imem_req !== 1'b1) begin n_fails++; $display("[TB] FAIL rm_pre_req: got %b expected 1", imem_req); end
        reset = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fails++; $display("[TB] FAIL rm_req: got %b expected 0", imem_req); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL rm_valid: got %b expected 0", instr_valid); end
        n_checks++; if (pc !== 32'h0) begin n_fails++; $display("[TB] FAIL rm_pc: got %h expected 00000000", pc); end
        n_checks++; if (fetch_err !== 1'b0) begin n_fails++; $display("[TB] FAIL rm_err: got %b expected 0", fetch_err); end
        imem_ack   = 1'b1;
        imem_rdata = 32'h9999_9999;
        repeat (2) tick();
        reset = 1'b1;
        n_checks++; if (imem_req !== 1'b0) begin n_fails++; $display("[TB] FAIL rm_boot_req: got %b expected 0", imem_req); end
        tick();
        n_checks++; if (imem_req !== 1'b1) begin n_fails++; $display("[TB] FAIL rm_fetch_req: got %b expected 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h0) begin n_fails++; $display("[TB] FAIL rm_fetch_addr: got %h expected 00000000", imem_addr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL rm_stale_ack: got %b expected 0", instr_valid); end
        imem_ack = 1'b0;
    endtask

    task automatic test_ack_on_expiry();
        repeat (14) tick();
        n_checks++; if (imem_req !== 1'b1) begin n_fails++; $display("[TB] FAIL exp_req: got %b expected 1", imem_req); end
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack   = 1'b0;
        n_checks++; if (instr !== 32'hDEAD_BEEF) begin n_fails++; $display("[TB] FAIL exp_instr: got %h expected deadbeef", instr); end
        n_checks++; if (instr_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL exp_valid: got %b expected 1", instr_valid); end
        n_checks++; if (fetch_err !== 1'b0) begin n_fails++; $display("[TB] FAIL exp_err: got %b expected 0", fetch_err); end
    endtask

    initial begin
        #1;
        test_reset();
        test_boot();
        test_sequential();
        test_branch();
        test_jumps();
        test_ignored_inputs();
        test_wrap();
        test_timeout();
        test_reset_mid();
        test_ack_on_expiry();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete within 100000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the MIPS controller/datapath. Holds the PC and issues word fetches to instruction memory over a req/ack handshake. Presents the fetched instruction (op/funct source for the controller) until the datapath retires it. Computes the next PC from the controller's pcsrc and jump outputs.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT, 15, max cycles imem_req may wait for imem_ack before error substitution (1..255)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_req  out  1  fetch request, held until acked
imem_addr  out  32  fetch address (= pc), stable while imem_req high
imem_ack  in  1  memory has data on imem_rdata this cycle
imem_rdata  in  32  fetched instruction word
instr  out  32  registered instruction to controller/datapath
instr_valid  out  1  instr is valid and awaiting retirement
pc  out  32  address of current instr
pc_plus4  out  32  pc + 4 (link value for JAL/JALR)
advance  in  1  datapath retires current instr this cycle
pcsrc  in  1  controller branch-taken
jump  in  4  controller jump code, one-hot: 0001 J, 0010 JAL, 0100 JR, 1000 JALR
imm  in  32  sign-extended branch immediate (word offset)
jr_target  in  32  rs value for JR/JALR
fetch_err  out  1  sticky: a fetch timed out since reset

Behaviour:
- Reset (reset low, async): pc=RESET_PC, state=BOOT, imem_req=0, instr=0, instr_valid=0, fetch_err=0, wait counter=0. Reset mid-fetch drops imem_req immediately; an outstanding ack after release is ignored.
- States: BOOT -> FETCH (unconditional, one cycle after reset release). FETCH: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, instr_valid<=1, -> HOLD. HOLD: imem_req=0; on advance: pc<=next_pc, instr_valid<=0, -> FETCH.
- Latency: ack sampled at edge N -> instr_valid high from N. advance sampled at edge M -> imem_req high with new address from M.
- advance while not in HOLD: ignored. imem_ack while imem_req low: ignored.
- Wait counter increments each FETCH cycle without ack; clears on entering FETCH. Reaching TIMEOUT without ack: instr<=32'h0 (NOP), instr_valid<=1, fetch_err<=1 (sticky until reset), -> HOLD; pc unchanged, normal advance thereafter. Ack in same cycle as expiry: ack wins, no error.
- next_pc priority: (1) jump J/JAL: {pc_plus4[31:28], instr[25:0], 2'b00}; (2) JR/JALR: {jr_target[31:2], 2'b00} (low bits forced zero); (3) pcsrc=1: pc_plus4 + (imm << 2); (4) else pc_plus4. jump with several bits set: lowest set bit wins. jump decode overrides pcsrc.
- All PC arithmetic 32-bit modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal, no flag.
- pc_plus4 combinational from pc; all other outputs registered.

Decomposition:
- Package mips_fetch_pkg: state enum (BOOT, FETCH, HOLD), jump one-hot constants (JMP_J, JMP_JAL, JMP_JR, JMP_JALR), NOP constant 32'h0.
- One sub-module: next_pc_sel (purely combinational next-PC mux/adders); FSM, counter and registers stay in fetch_unit.

Test Plan:
- Boot: release reset, RESET_PC=0 -> imem_req=1, imem_addr=0 one cycle later; ack with rdata 32'h2008_0005 -> instr=32'h2008_0005, instr_valid=1, imem_req=0.
- Sequential: HOLD at pc=0, advance, pcsrc=0, jump=0 -> next imem_addr=32'h4; pc_plus4=32'h8 after update.
- Branch: pc=32'h10, advance, pcsrc=1, imm=32'hFFFF_FFFE -> imem_addr=32'h0C; same with jump=0001 and instr=32'h0800_0100 -> imem_addr=32'h400 (jump overrides pcsrc).
- JR: pc=32'h0040_0010, jump=0100, jr_target=32'h0040_0023 -> imem_addr=32'h0040_0020; advance outside HOLD produces no PC change.
- Timeout: TIMEOUT=15, hold imem_ack=0 -> on 15th FETCH cycle instr=0, instr_valid=1, fetch_err=1, pc unchanged; fetch_err stays 1 across later successful fetches; ack on the expiry cycle -> fetch_err stays 0.
- Reset mid-operation: assert reset while imem_req=1 -> imem_req, instr_valid drop same cycle (async), pc=RESET_PC; fetch restarts at RESET_PC after BOOT.
